// File: rtl/pulse_chain_seq_pkg.sv
// ---------------------------------------------------------------------------
// pulse_chain_seq_pkg
//
// Shared timing definitions for blocks built on the 50 MHz emulation clock.
// One tick is 20 ns. The helper ns2ticks() converts nanoseconds into ticks
// using truncating division. Instantiating blocks use it to build the packed
// per-step delay vector that drives pulse_chain_seq.
//
// The named tick constants reproduce the delay values of the legacy
// fixed-delay units. The values are truncated, so 250 ns maps to 12 ticks
// (240 ns). Keep them identical to the old parts so that control sequences
// retain their cycle-exact timing.
// ---------------------------------------------------------------------------
package pulse_chain_seq_pkg;

   localparam int TICK_NS = 20;

   // Nanoseconds to whole ticks (truncating).
   function automatic int ns2ticks(input int ns);
      return ns / TICK_NS;
   endfunction

   // Legacy delay-unit set, expressed in ticks.
   localparam int T_50NS  = 2;
   localparam int T_70NS  = 3;
   localparam int T_100NS = 5;
   localparam int T_150NS = 7;
   localparam int T_200NS = 10;
   localparam int T_250NS = 12;
   localparam int T_300NS = 15;
   localparam int T_400NS = 20;
   localparam int T_450NS = 22;
   localparam int T_550NS = 27;
   localparam int T_750NS = 37;
   localparam int T_800NS = 40;
   localparam int T_1US   = 50;

endpackage

// File: rtl/pulse_chain_seq_tick_cnt.sv
// ---------------------------------------------------------------------------
// seq_tick_cnt
//
// This is the per-step tick counter of the pulse chain. It holds the running
// tick count and the delay that was latched when the current step was
// entered.
//
//   clk      in   system clock
//   reset    in   asynchronous active-high reset; clears count and delay
//   clr      in   return to idle (count = 0); has priority over load
//   load     in   enter a new step: count = 1, delay = load_val
//   load_val in   effective delay of the step being entered (never 0)
//   active   out  count != 0 (a step is in progress)
//   hit      out  count has reached the latched delay this cycle
//
// A count of 0 means idle. While the counter is active it increments every
// cycle. Because load_val is always at least 1 and the owner reloads or
// clears the counter on the hit cycle, the count cannot pass the delay and
// never wraps. The hit output is decoded only from the two registers.
// ---------------------------------------------------------------------------
module seq_tick_cnt
   import pulse_chain_seq_pkg::*;
#(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          active,
   output logic          hit
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [CW-1:0] dcur_q;
   logic [CW-1:0] dcur_d;

   always_comb begin
      cnt_d  = cnt_q;
      dcur_d = dcur_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d  = CW'(1);
         dcur_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         dcur_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         dcur_q <= dcur_d;
      end
   end

   assign active = (cnt_q != '0);
   assign hit    = active && (cnt_q == dcur_q);

endmodule

// File: rtl/pulse_chain_seq.sv
// ---------------------------------------------------------------------------
// pulse_chain_seq
//
// This is a programmable timing-chain sequencer. A start pulse launches a
// chain of NSTEPS one-cycle step pulses. Each pulse is spaced from the
// previous one by its own tick count.
//
//   clk     in   system clock (50 MHz, 20 ns/tick)
//   reset   in   asynchronous active-high reset; clears all state
//   start   in   one-cycle launch; restarts the chain if it is already busy
//   stop    in   one-cycle abort; wins over start
//   dly     in   step k delay in ticks at [k*CW +: CW]; 0 is treated as 1
//   p       out  p[k] high for exactly one cycle when step k fires
//   busy    out  high while a step is counting
//   done    out  coincident with the final step pulse
//   retrig  out  one-cycle pulse after a start that was accepted while busy
//
// The edge priority is reset, then stop, then start, then step advance or
// count. Every output is decoded from registers, so no input reaches an
// output combinationally. When a start lands on a pulse cycle, the pulse is
// still emitted, but the chain restarts at step 0 and does not advance.
// ---------------------------------------------------------------------------
module pulse_chain_seq
   import pulse_chain_seq_pkg::*;
#(
   parameter int NSTEPS = 4,
   parameter int CW     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 stop,
   input  logic [NSTEPS*CW-1:0] dly,
   output logic [NSTEPS-1:0]    p,
   output logic                 busy,
   output logic                 done,
   output logic                 retrig
);

   localparam int SW = $clog2(NSTEPS);

   logic [SW-1:0] s_q;
   logic [SW-1:0] s_d;
   logic          retrig_q;
   logic          retrig_d;

   logic [CW-1:0] eff_dly [NSTEPS];
   logic [SW-1:0] s_inc;
   logic          last_step;

   logic          cnt_clr;
   logic          cnt_load;
   logic [CW-1:0] cnt_load_val;
   logic          cnt_active;
   logic          cnt_hit;

   // A zero delay behaves as one tick. The shortest chain therefore produces
   // back-to-back pulses rather than collapsing them.
   genvar gi;
   generate
      for (gi = 0; gi < NSTEPS; gi++) begin : g_eff
         assign eff_dly[gi] = (dly[gi*CW +: CW] == '0) ? CW'(1) : dly[gi*CW +: CW];
      end
   endgenerate

   assign last_step = (s_q == SW'(NSTEPS-1));
   // This wraps explicitly so the delay mux never sees an out-of-range index.
   // That matters when NSTEPS is not a power of two.
   assign s_inc     = last_step ? '0 : s_q + SW'(1);

   // -----------------------------------------------------------------------
   // Step control and priority
   // -----------------------------------------------------------------------
   always_comb begin
      cnt_clr      = 1'b0;
      cnt_load     = 1'b0;
      cnt_load_val = eff_dly[0];
      s_d          = s_q;
      retrig_d     = 1'b0;
      if (stop) begin
         cnt_clr = 1'b1;
         s_d     = '0;
      end else if (start) begin
         cnt_load     = 1'b1;
         cnt_load_val = eff_dly[0];
         s_d          = '0;
         retrig_d     = cnt_active;
      end else if (cnt_hit) begin
         if (last_step) begin
            cnt_clr = 1'b1;
            s_d     = '0;
         end else begin
            // Latch the next delay now. Later changes on dly do not affect
            // the step that is entered here.
            cnt_load     = 1'b1;
            cnt_load_val = eff_dly[s_inc];
            s_d          = s_inc;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_q      <= '0;
         retrig_q <= 1'b0;
      end else begin
         s_q      <= s_d;
         retrig_q <= retrig_d;
      end
   end

   seq_tick_cnt #(
      .CW(CW)
   ) u_tick_cnt (
      .clk      (clk),
      .reset    (reset),
      .clr      (cnt_clr),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .active   (cnt_active),
      .hit      (cnt_hit)
   );

   // -----------------------------------------------------------------------
   // Outputs (registers only)
   // -----------------------------------------------------------------------
   generate
      for (gi = 0; gi < NSTEPS; gi++) begin : g_pulse
         assign p[gi] = cnt_hit && (s_q == SW'(gi));
      end
   endgenerate

   assign busy   = cnt_active;
   assign done   = p[NSTEPS-1];
   assign retrig = retrig_q;

endmodule

// File: tb/tb_pulse_chain_seq.sv
// ---------------------------------------------------------------------------
// tb_pulse_chain_seq
//
// Directed bench for pulse_chain_seq with NSTEPS=4 and CW=8. Cycle c of a
// scenario is the interval after the c-th clock edge that follows the cycle
// in which start was asserted (cycle 0). Outputs are sampled 1 time unit
// after each rising edge.
// ---------------------------------------------------------------------------
module tb_pulse_chain_seq;
   import pulse_chain_seq_pkg::*;

   localparam int NSTEPS = 4;
   localparam int CW     = 8;

   logic                 clk;
   logic                 reset;
   logic                 start;
   logic                 stop;
   logic [NSTEPS*CW-1:0] dly;
   logic [NSTEPS-1:0]    p;
   logic                 busy;
   logic                 done;
   logic                 retrig;

   int checks;
   int errors;

   pulse_chain_seq #(
      .NSTEPS(NSTEPS),
      .CW    (CW)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .stop   (stop),
      .dly    (dly),
      .p      (p),
      .busy   (busy),
      .done   (done),
      .retrig (retrig)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NSTEPS*CW-1:0] pack(input int d0, input int d1, input int d2, input int d3);
      return {CW'(d3), CW'(d2), CW'(d1), CW'(d0)};
   endfunction

   // -----------------------------------------------------------------------
   task automatic test_reset();
      reset = 1'b1; start = 1'b0; stop = 1'b0; dly = '0;
      tick(); tick();
      checks++;
      if ({p, busy, done, retrig} !== 7'b0) begin
         errors++;
         $display("FAIL reset_hold got p=%b busy=%b done=%b retrig=%b exp all 0", p, busy, done, retrig);
      end
      reset = 1'b0;
      tick(); tick();
      checks++;
      if ({p, busy, done, retrig} !== 7'b0) begin
         errors++;
         $display("FAIL reset_release got p=%b busy=%b done=%b retrig=%b exp all 0", p, busy, done, retrig);
      end
      $display("test_reset: outputs idle after reset");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_basic();
      logic [NSTEPS-1:0] exp_p;
      dly   = pack(T_50NS, T_100NS, T_200NS, T_70NS);   // {2,5,10,3}
      start = 1'b1;
      for (int c = 1; c <= 22; c++) begin
         tick();
         start = 1'b0;
         case (c)
            2:  exp_p = 4'b0001;
            7:  exp_p = 4'b0010;
            17: exp_p = 4'b0100;
            20: exp_p = 4'b1000;
            default: exp_p = 4'b0000;
         endcase
         checks += 4;
         if (p !== exp_p) begin errors++; $display("FAIL basic_p cyc %0d got %b exp %b", c, p, exp_p); end
         if (busy !== (c <= 20)) begin errors++; $display("FAIL basic_busy cyc %0d got %b exp %b", c, busy, (c <= 20)); end
         if (done !== exp_p[3]) begin errors++; $display("FAIL basic_done cyc %0d got %b exp %b", c, done, exp_p[3]); end
         if (retrig !== 1'b0) begin errors++; $display("FAIL basic_retrig cyc %0d got %b exp 0", c, retrig); end
      end
      $display("test_basic: chain {2,5,10,3} checked over 22 cycles");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_zero_one();
      logic [NSTEPS-1:0] exp_p;
      dly   = pack(0, 1, 0, 1);
      start = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick();
         start = 1'b0;
         case (c)
            1: exp_p = 4'b0001;
            2: exp_p = 4'b0010;
            3: exp_p = 4'b0100;
            4: exp_p = 4'b1000;
            default: exp_p = 4'b0000;
         endcase
         checks += 3;
         if (p !== exp_p) begin errors++; $display("FAIL zero_p cyc %0d got %b exp %b", c, p, exp_p); end
         if (busy !== (c <= 4)) begin errors++; $display("FAIL zero_busy cyc %0d got %b exp %b", c, busy, (c <= 4)); end
         if (done !== exp_p[3]) begin errors++; $display("FAIL zero_done cyc %0d got %b exp %b", c, done, exp_p[3]); end
      end
      $display("test_zero_one: chain {0,1,0,1} checked over 6 cycles");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_retrigger();
      logic [NSTEPS-1:0] exp_p;
      dly   = pack(5, 5, 5, 5);
      start = 1'b1;
      for (int c = 1; c <= 29; c++) begin
         tick();
         case (c)
            5, 12: exp_p = 4'b0001;
            17:    exp_p = 4'b0010;
            22:    exp_p = 4'b0100;
            27:    exp_p = 4'b1000;
            default: exp_p = 4'b0000;
         endcase
         checks += 3;
         if (p !== exp_p) begin errors++; $display("FAIL retrig_p cyc %0d got %b exp %b", c, p, exp_p); end
         if (busy !== (c <= 27)) begin errors++; $display("FAIL retrig_busy cyc %0d got %b exp %b", c, busy, (c <= 27)); end
         if (retrig !== (c == 8)) begin errors++; $display("FAIL retrig_flag cyc %0d got %b exp %b", c, retrig, (c == 8)); end
         start = (c == 7);
      end
      $display("test_retrigger: restart at cycle 7 checked over 29 cycles");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_abort();
      logic [NSTEPS-1:0] exp_p;
      dly   = pack(2, 5, 10, 3);
      start = 1'b1;
      for (int c = 1; c <= 22; c++) begin
         tick();
         start = 1'b0;
         stop  = 1'b0;
         exp_p = (c == 2) ? 4'b0001 : 4'b0000;
         checks += 2;
         if (p !== exp_p) begin errors++; $display("FAIL abort_p cyc %0d got %b exp %b", c, p, exp_p); end
         if (busy !== (c <= 6)) begin errors++; $display("FAIL abort_busy cyc %0d got %b exp %b", c, busy, (c <= 6)); end
         stop = (c == 6);
      end
      // Start and stop together: stop wins, the block stays idle.
      start = 1'b1;
      stop  = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         start = 1'b0;
         stop  = 1'b0;
         checks++;
         if ({p, busy, retrig} !== 6'b0) begin
            errors++;
            $display("FAIL collide cyc %0d got p=%b busy=%b retrig=%b exp all 0", c, p, busy, retrig);
         end
      end
      $display("test_abort: stop at cycle 6 and start+stop collision checked");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_dly_change();
      logic [NSTEPS-1:0] exp_p;
      dly   = pack(2, 5, 10, 3);
      start = 1'b1;
      for (int c = 1; c <= 18; c++) begin
         tick();
         start = 1'b0;
         case (c)
            2:  exp_p = 4'b0001;
            7:  exp_p = 4'b0010;
            13: exp_p = 4'b0100;
            16: exp_p = 4'b1000;
            default: exp_p = 4'b0000;
         endcase
         checks += 2;
         if (p !== exp_p) begin errors++; $display("FAIL dlychg_p cyc %0d got %b exp %b", c, p, exp_p); end
         if (busy !== (c <= 16)) begin errors++; $display("FAIL dlychg_busy cyc %0d got %b exp %b", c, busy, (c <= 16)); end
         if (c == 4) dly = pack(2, 9, 6, 3);
      end
      $display("test_dly_change: mid-step dly update checked over 18 cycles");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_back_to_back();
      logic [NSTEPS-1:0] exp_p;
      dly   = pack(0, 1, 0, 1);
      start = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         case (c)
            1, 5: exp_p = 4'b0001;
            2, 6: exp_p = 4'b0010;
            3, 7: exp_p = 4'b0100;
            4, 8: exp_p = 4'b1000;
            default: exp_p = 4'b0000;
         endcase
         checks += 4;
         if (p !== exp_p) begin errors++; $display("FAIL b2b_p cyc %0d got %b exp %b", c, p, exp_p); end
         if (busy !== (c <= 8)) begin errors++; $display("FAIL b2b_busy cyc %0d got %b exp %b", c, busy, (c <= 8)); end
         if (done !== exp_p[3]) begin errors++; $display("FAIL b2b_done cyc %0d got %b exp %b", c, done, exp_p[3]); end
         if (retrig !== (c == 5)) begin errors++; $display("FAIL b2b_retrig cyc %0d got %b exp %b", c, retrig, (c == 5)); end
         start = (c == 4);
      end
      $display("test_back_to_back: relaunch in done cycle checked");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_async_reset();
      logic [NSTEPS-1:0] exp_p;
      dly   = pack(2, 5, 10, 3);
      start = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         tick();
         start = 1'b0;
         case (c)
            2:  exp_p = 4'b0001;
            7:  exp_p = 4'b0010;
            default: exp_p = 4'b0000;
         endcase
         checks += 2;
         if (p !== exp_p) begin errors++; $display("FAIL arst_pre_p cyc %0d got %b exp %b", c, p, exp_p); end
         if (busy !== 1'b1) begin errors++; $display("FAIL arst_pre_busy cyc %0d got %b exp 1", c, busy); end
      end
      // Assert reset between edges. The outputs must clear without a clock.
      reset = 1'b1;
      #1;
      checks++;
      if ({p, busy, done, retrig} !== 7'b0) begin
         errors++;
         $display("FAIL arst_async got p=%b busy=%b done=%b retrig=%b exp all 0", p, busy, done, retrig);
      end
      tick(); tick(); tick();
      reset = 1'b0;
      for (int c = 13; c <= 33; c++) begin
         tick();
         start = 1'b0;
         exp_p = (c == 32) ? 4'b0001 : 4'b0000;
         checks += 2;
         if (p !== exp_p) begin errors++; $display("FAIL arst_post_p cyc %0d got %b exp %b", c, p, exp_p); end
         if (busy !== (c >= 31)) begin errors++; $display("FAIL arst_post_busy cyc %0d got %b exp %b", c, busy, (c >= 31)); end
         start = (c == 30);
      end
      // Clear the relaunched chain before finishing.
      stop = 1'b1;
      tick();
      stop = 1'b0;
      $display("test_async_reset: reset at cycle 9, relaunch at cycle 30 checked");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_zero_one();
      test_retrigger();
      test_abort();
      test_dly_change();
      test_back_to_back();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
